// File: rtl/inst_rom_arb.sv
// Two-port arbiter (instruction fetch / constant load) in front of a single-ported code ROM.
// One access is outstanding at a time; the fetch port's response can be discarded by a flush.
`timescale 1ns/1ps
module inst_rom_arb #(
   parameter int ROM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_flush_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   input  logic        ls_req_i,
   input  logic [31:0] ls_addr_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,
   output logic [31:0] rdata_o,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   output logic        state_dbg
);

   // Handshake: a request is accepted in the cycle its gnt is high (only possible in IDLE);
   // the matching rvalid is a single-cycle pulse ROM_LAT+1 cycles later, with rdata_o valid in it.

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   state_t     state_q, state_d;
   logic       owner_q;
   logic       last_owner_q;
   logic [3:0] cnt_q;
   logic       flushed_q;
   logic       flush_hit;
   logic       done;
   logic       deliver;

   assign state_dbg = state_q;

   always_comb begin
      if_gnt_o  = 1'b0;
      ls_gnt_o  = 1'b0;
      state_d   = state_q;
      flush_hit = 1'b0;
      done      = 1'b0;
      deliver   = 1'b0;
      if (!rst && state_q == IDLE) begin
         // On a tie the port that did not win last time gets the ROM.
         if (if_req_i && (!ls_req_i || last_owner_q == OWN_LS)) begin
            if_gnt_o = 1'b1;
         end else if (ls_req_i) begin
            ls_gnt_o = 1'b1;
         end
      end
      if (state_q == IDLE) begin
         if (if_gnt_o || ls_gnt_o) begin
            state_d = ACCESS;
         end
      end else begin
         flush_hit = if_flush_i && (owner_q == OWN_IF);
         done      = (cnt_q == 4'd0);
         deliver   = done && !flushed_q && !flush_hit;
         if (done) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_LS;
         cnt_q        <= 4'd0;
         flushed_q    <= 1'b0;
         rom_ce_o     <= 1'b0;
         rom_addr_o   <= 32'd0;
         rdata_o      <= 32'd0;
         if_rvalid_o  <= 1'b0;
         ls_rvalid_o  <= 1'b0;
      end else begin
         state_q     <= state_d;
         if_rvalid_o <= 1'b0;
         ls_rvalid_o <= 1'b0;
         if (state_q == IDLE) begin
            if (if_gnt_o || ls_gnt_o) begin
               rom_ce_o     <= 1'b1;
               rom_addr_o   <= if_gnt_o ? if_addr_i : ls_addr_i;
               owner_q      <= ls_gnt_o;
               last_owner_q <= ls_gnt_o;
               cnt_q        <= 4'(ROM_LAT - 1);
               flushed_q    <= 1'b0;
            end else begin
               rom_ce_o <= 1'b0;
            end
         end else begin
            if (flush_hit) begin
               flushed_q <= 1'b1;
            end
            if (!done) begin
               cnt_q <= cnt_q - 4'd1;
            end else begin
               rom_ce_o <= 1'b0;
               // A flushed fetch finishes its ROM cycle but leaves rdata_o untouched.
               if (deliver) begin
                  rdata_o     <= rom_data_i;
                  if_rvalid_o <= (owner_q == OWN_IF);
                  ls_rvalid_o <= (owner_q == OWN_LS);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_rom_arb.sv
// Bench for inst_rom_arb: directed vector table on a ROM_LAT=1 instance, hand sequences,
// and a randomized run on a ROM_LAT=3 instance against a cycle-count reference model.
`timescale 1ns/1ps
module tb_inst_rom_arb;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
   endfunction

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_if_req, a_flush, a_ls_req, a_if_gnt, a_ls_gnt, a_if_rv, a_ls_rv, a_ce, a_dbg;
   logic [31:0] a_if_addr, a_ls_addr, a_rdata, a_rom_addr, a_rom_data;
   logic        b_rst, b_if_req, b_flush, b_ls_req, b_if_gnt, b_ls_gnt, b_if_rv, b_ls_rv, b_ce, b_dbg;
   logic [31:0] b_if_addr, b_ls_addr, b_rdata, b_rom_addr, b_rom_data;

   assign a_rom_data = rom_word(a_rom_addr);
   assign b_rom_data = rom_word(b_rom_addr);

   inst_rom_arb #(.ROM_LAT(LAT_A)) dut_a (
      .clk(clk), .rst(a_rst),
      .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_flush_i(a_flush),
      .if_gnt_o(a_if_gnt), .if_rvalid_o(a_if_rv),
      .ls_req_i(a_ls_req), .ls_addr_i(a_ls_addr),
      .ls_gnt_o(a_ls_gnt), .ls_rvalid_o(a_ls_rv),
      .rdata_o(a_rdata), .rom_ce_o(a_ce), .rom_addr_o(a_rom_addr),
      .rom_data_i(a_rom_data), .state_dbg(a_dbg)
   );

   inst_rom_arb #(.ROM_LAT(LAT_B)) dut_b (
      .clk(clk), .rst(b_rst),
      .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_flush_i(b_flush),
      .if_gnt_o(b_if_gnt), .if_rvalid_o(b_if_rv),
      .ls_req_i(b_ls_req), .ls_addr_i(b_ls_addr),
      .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rv),
      .rdata_o(b_rdata), .rom_ce_o(b_ce), .rom_addr_o(b_rom_addr),
      .rom_data_i(b_rom_data), .state_dbg(b_dbg)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // vector table
   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        ls_req;
      logic [31:0] ls_addr;
      logic        flush;
      logic        e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_ce;
      logic [31:0] e_addr;
      logic [31:0] e_data;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la,
                      input logic fl, input logic eig, input logic elg, input logic eirv,
                      input logic elrv, input logic ece, input logic [31:0] eaddr,
                      input logic [31:0] edata);
      vec_t v;
      v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_addr = la; v.flush = fl;
      v.e_if_gnt = eig; v.e_ls_gnt = elg; v.e_if_rv = eirv; v.e_ls_rv = elrv; v.e_ce = ece;
      v.e_addr = eaddr; v.e_data = edata;
      vecs.push_back(v);
   endtask

   // driver tasks
   task automatic drive_a(input logic rst_v, input logic ir, input logic [31:0] ia,
                          input logic lr, input logic [31:0] la, input logic fl);
      @(posedge clk); #1;
      a_rst = rst_v; a_if_req = ir; a_if_addr = ia; a_ls_req = lr; a_ls_addr = la; a_flush = fl;
   endtask

   task automatic drive_b(input logic rst_v, input logic ir, input logic [31:0] ia,
                          input logic lr, input logic [31:0] la, input logic fl);
      @(posedge clk); #1;
      b_rst = rst_v; b_if_req = ir; b_if_addr = ia; b_ls_req = lr; b_ls_addr = la; b_flush = fl;
   endtask

   // scoreboard state for the randomized run
   logic [32:0] exp_q[$];   // {port (1 = load), data}
   int          free_cyc;
   int          gnt_cyc;
   int          due_cyc;
   logic        pend_flushed;
   logic        last_ls;
   logic [31:0] last_data;

   initial begin
      logic [31:0] hold;
      a_rst = 1'b1; a_if_req = 1'b0; a_if_addr = '0; a_ls_req = 1'b0; a_ls_addr = '0; a_flush = 1'b0;
      b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = '0; b_ls_req = 1'b0; b_ls_addr = '0; b_flush = 1'b0;

      // reset behaviour: no grants while reset is high even with both requests
      drive_a(1, 1, 32'h100, 1, 32'h200, 0);
      @(negedge clk);
      check("rst_if_gnt", a_if_gnt, 0);
      check("rst_ls_gnt", a_ls_gnt, 0);
      drive_a(1, 1, 32'h100, 1, 32'h200, 0);
      @(negedge clk);
      check("rst_ce", a_ce, 0);
      check("rst_addr", a_rom_addr, 0);
      check("rst_rdata", a_rdata, 0);
      check("rst_rvalid", {a_if_rv, a_ls_rv}, 0);
      check("rst_state", a_dbg, 0);

      // alternating grants on continuous ties, then single fetch, flushes, load immune to flush
      add(1, 32'h100, 1, 32'h200, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h100, 0);
      add(1, 32'h100, 1, 32'h200, 0, 0, 1, 1, 0, 0, 0, rom_word(32'h100));
      add(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h200, 0);
      add(1, 32'h100, 1, 32'h200, 0, 1, 0, 0, 1, 0, 0, rom_word(32'h200));
      add(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h100, 0);
      add(1, 32'h100, 1, 32'h200, 0, 0, 1, 1, 0, 0, 0, rom_word(32'h100));
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, rom_word(32'h200));
      add(1, 32'h10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, rom_word(32'h10));
      add(1, 32'h40, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h40, 0);
      add(1, 32'h44, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, rom_word(32'h44));
      add(1, 32'h48, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h48, 0);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, rom_word(32'h48));
      add(0, 0, 1, 32'h60, 0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h60, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, rom_word(32'h60));

      hold = 32'd0;
      for (int i = 0; i < vecs.size(); i++) begin
         drive_a(0, vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req, vecs[i].ls_addr, vecs[i].flush);
         @(negedge clk);
         check($sformatf("v%0d_if_gnt", i), a_if_gnt, vecs[i].e_if_gnt);
         check($sformatf("v%0d_ls_gnt", i), a_ls_gnt, vecs[i].e_ls_gnt);
         check($sformatf("v%0d_if_rv", i), a_if_rv, vecs[i].e_if_rv);
         check($sformatf("v%0d_ls_rv", i), a_ls_rv, vecs[i].e_ls_rv);
         check($sformatf("v%0d_ce", i), a_ce, vecs[i].e_ce);
         if (vecs[i].e_ce) check($sformatf("v%0d_addr", i), a_rom_addr, vecs[i].e_addr);
         if (vecs[i].e_if_rv || vecs[i].e_ls_rv) hold = vecs[i].e_data;
         check($sformatf("v%0d_rdata", i), a_rdata, hold);
      end

      // reset during an outstanding access, then first tie goes to fetch
      drive_a(0, 1, 32'h80, 0, 0, 0);
      @(negedge clk);
      check("rsta_gnt", a_if_gnt, 1);
      drive_a(1, 1, 32'h80, 1, 32'h90, 0);
      @(negedge clk);
      check("rsta_ce_in_rst", a_ce, 1);
      check("rsta_gnt_in_rst", {a_if_gnt, a_ls_gnt}, 0);
      drive_a(0, 1, 32'h84, 1, 32'h88, 0);
      @(negedge clk);
      check("rsta_ce_after", a_ce, 0);
      check("rsta_rv_after", {a_if_rv, a_ls_rv}, 0);
      check("rsta_rdata", a_rdata, 0);
      check("rsta_tie", {a_if_gnt, a_ls_gnt}, 2'b10);
      drive_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("rsta_ce2", a_ce, 1);
      drive_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("rsta_rv2", {a_if_rv, a_ls_rv}, 2'b10);
      check("rsta_data2", a_rdata, rom_word(32'h84));

      // ROM_LAT=3 latency with a load, fetch request kept pending
      drive_b(1, 0, 0, 0, 0, 0);
      drive_b(1, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 1, 32'h20, 0);
      @(negedge clk);
      check("l3_ls_gnt", {b_if_gnt, b_ls_gnt}, 2'b01);
      for (int c = 1; c <= 3; c++) begin
         drive_b(0, 1, 32'h30, 1, 32'h24, 0);
         @(negedge clk);
         check($sformatf("l3_c%0d_ce", c), b_ce, 1);
         check($sformatf("l3_c%0d_addr", c), b_rom_addr, 32'h20);
         check($sformatf("l3_c%0d_gnt", c), {b_if_gnt, b_ls_gnt}, 0);
         check($sformatf("l3_c%0d_rv", c), {b_if_rv, b_ls_rv}, 0);
      end
      drive_b(0, 1, 32'h30, 1, 32'h24, 0);
      @(negedge clk);
      check("l3_c4_rv", {b_if_rv, b_ls_rv}, 2'b01);
      check("l3_c4_data", b_rdata, rom_word(32'h20));
      check("l3_c4_ce", b_ce, 0);
      check("l3_c4_gnt", {b_if_gnt, b_ls_gnt}, 2'b10);

      // randomized run on ROM_LAT=3 against the reference model
      drive_b(1, 0, 0, 0, 0, 0);
      drive_b(1, 0, 0, 0, 0, 0);
      free_cyc = 0; gnt_cyc = 0; due_cyc = 0; pend_flushed = 1'b0; last_ls = 1'b1;
      last_data = 32'd0; exp_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        e_ig, e_lg, e_irv, e_lrv;
         logic [32:0] e;
         drive_b($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, $urandom(),
                 $urandom_range(0, 99) < 50, $urandom(), $urandom_range(0, 99) < 15);
         @(negedge clk);
         e_ig = 1'b0; e_lg = 1'b0; e_irv = 1'b0; e_lrv = 1'b0;
         if (!b_rst && cyc >= free_cyc) begin
            if (b_if_req && b_ls_req) begin
               if (last_ls) e_ig = 1'b1; else e_lg = 1'b1;
            end else begin
               e_ig = b_if_req;
               e_lg = b_ls_req;
            end
         end
         if (exp_q.size() != 0 && cyc == due_cyc) begin
            e = exp_q.pop_front();
            if (!pend_flushed) begin
               if (e[32]) e_lrv = 1'b1; else e_irv = 1'b1;
               last_data = e[31:0];
            end
         end
         check($sformatf("r%0d_if_gnt", cyc), b_if_gnt, e_ig);
         check($sformatf("r%0d_ls_gnt", cyc), b_ls_gnt, e_lg);
         check($sformatf("r%0d_if_rv", cyc), b_if_rv, e_irv);
         check($sformatf("r%0d_ls_rv", cyc), b_ls_rv, e_lrv);
         check($sformatf("r%0d_gnt_excl", cyc), b_if_gnt & b_ls_gnt, 0);
         check($sformatf("r%0d_rv_excl", cyc), b_if_rv & b_ls_rv, 0);
         check($sformatf("r%0d_rdata", cyc), b_rdata, last_data);
         if (exp_q.size() != 0 && !exp_q[0][32] && b_flush && cyc > gnt_cyc && cyc < due_cyc)
            pend_flushed = 1'b1;
         if (b_rst) begin
            exp_q.delete();
            free_cyc  = cyc + 1;
            last_ls   = 1'b1;
            last_data = 32'd0;
         end else if (e_ig || e_lg) begin
            exp_q.push_back({e_lg, rom_word(e_lg ? b_ls_addr : b_if_addr)});
            gnt_cyc      = cyc;
            due_cyc      = cyc + LAT_B + 1;
            free_cyc     = due_cyc;
            pend_flushed = 1'b0;
            last_ls      = e_lg;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
